// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter that shares one single-port memory among NUM_REQ agents,
// running one transaction at a time and aborting any that the memory never acknowledges.
module mem_rr_arbiter #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_wr_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [NUM_REQ-1:0]            req_err,
    output logic [WIDTH-1:0]              rsp_rdata,
    output logic                          wr_rd,
    output logic [ADDR_WIDTH-1:0]         addr,
    output logic [WIDTH-1:0]              wdata,
    output logic                          valid,
    input  logic [WIDTH-1:0]              rdata,
    input  logic                          ready,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 2 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_params
            $error("mem_rr_arbiter: illegal parameter combination");
        end
    endgenerate

    // Handshake: valid is raised with wr_rd/addr/wdata and holds them stable until an
    // edge where valid && ready are both high (transfer, rdata sampled on that edge) or
    // until the timeout aborts; valid always drops for at least one cycle afterwards.
    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [CW-1:0]   tmo_cnt;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [WIDTH-1:0]      wdata_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
    end

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic                 any_req;
    logic [IDW-1:0]       pick;
    logic [IDW:0]         sum;

    // Rotate so bit 0 is rr_ptr; the lowest set rotated bit wins, mapped back mod NUM_REQ.
    always_comb begin
        req_dbl = {req_valid, req_valid} >> rr_ptr;
        req_rot = req_dbl[NUM_REQ-1:0];
        any_req = |req_rot;
        pick    = '0;
        sum     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                sum  = {1'b0, rr_ptr} + (IDW+1)'(i);
                pick = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ)) : IDW'(sum);
            end
        end
    end

    logic [IDW-1:0]     next_ptr;
    logic [NUM_REQ-1:0] grant_oh;

    assign next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    assign grant_oh = NUM_REQ'(1) << grant_id;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            tmo_cnt   <= '0;
            req_done  <= '0;
            req_err   <= '0;
            rsp_rdata <= '0;
            wr_rd     <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            grant_id  <= '0;
        end else begin
            req_done <= '0;
            req_err  <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= pick;
                        wr_rd    <= req_wr_rd[pick];
                        addr     <= addr_arr[pick];
                        wdata    <= wdata_arr[pick];
                        valid    <= 1'b1;
                        busy     <= 1'b1;
                        tmo_cnt  <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (valid && ready) begin
                        valid    <= 1'b0;
                        busy     <= 1'b0;
                        req_done <= grant_oh;
                        if (!wr_rd) begin
                            rsp_rdata <= rdata;
                        end
                        rr_ptr   <= next_ptr;
                        state    <= IDLE;
                    end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                        // Memory never answered: close out the grant with an error pulse.
                        valid     <= 1'b0;
                        busy      <= 1'b0;
                        req_done  <= grant_oh;
                        req_err   <= grant_oh;
                        rsp_rdata <= '0;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter: a small memory model answering one cycle after valid,
// and one task per scenario checking grants, completions, read data and timeouts.
module tb_mem_rr_arbiter;

  localparam int WIDTH      = 8;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = 4;
  localparam int NUM_REQ    = 4;
  localparam int TIMEOUT    = 8;

  logic        clk;
  logic        res;
  logic [3:0]  req_valid;
  logic [3:0]  req_wr_rd;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_done;
  logic [3:0]  req_err;
  logic [7:0]  rsp_rdata;
  logic        wr_rd;
  logic [3:0]  addr;
  logic [7:0]  wdata;
  logic        valid;
  logic [7:0]  rdata;
  logic        ready;
  logic        busy;
  logic [1:0]  grant_id;

  int checks = 0;
  int errors = 0;

  // observation state, owned by the main initial block
  int         rise_cnt;
  int         high_cnt;
  int         idle_run;
  logic       prev_valid;
  logic [1:0] grant_q[$];
  logic [3:0] done_q[$];
  logic [3:0] err_q[$];
  logic [7:0] rdata_q[$];
  int         gap_q[$];
  logic [1:0] exp_q[$];
  logic [3:0] oneshot;
  bit         mem_en;
  bit         ok;

  mem_rr_arbiter #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH),
    .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .res(res),
    .req_valid(req_valid), .req_wr_rd(req_wr_rd), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_done(req_done), .req_err(req_err), .rsp_rdata(rsp_rdata),
    .wr_rd(wr_rd), .addr(addr), .wdata(wdata), .valid(valid),
    .rdata(rdata), .ready(ready), .busy(busy), .grant_id(grant_id)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory: ready one cycle after valid, write on the transfer edge
  logic [7:0] mem [16] = '{default: 8'h00};
  always @(posedge clk) begin
    if (!res) ready <= 1'b0;
    else if (mem_en && valid && !ready) ready <= 1'b1;
    else ready <= 1'b0;
    if (res && valid && ready && wr_rd) mem[addr] <= wdata;
  end
  assign rdata = mem[addr];

  task automatic clear_mon();
    rise_cnt = 0;
    high_cnt = 0;
    idle_run = 0;
    prev_valid = valid;
    grant_q.delete();
    done_q.delete();
    err_q.delete();
    rdata_q.delete();
    gap_q.delete();
    exp_q.delete();
  endtask

  // one clock; sample 1ns after the edge and record bus activity
  task automatic step();
    @(posedge clk);
    #1;
    if (valid) begin
      high_cnt++;
      if (!prev_valid) begin
        rise_cnt++;
        grant_q.push_back(grant_id);
        if (rise_cnt > 1) gap_q.push_back(idle_run);
      end
      idle_run = 0;
    end else begin
      idle_run++;
    end
    if (req_done != 4'h0) begin
      done_q.push_back(req_done);
      err_q.push_back(req_err);
      rdata_q.push_back(rsp_rdata);
      req_valid = req_valid & ~(req_done & oneshot);
    end
    prev_valid = valid;
  endtask

  task automatic run_until(input int n, input int budget, output bit got);
    int k = 0;
    while (done_q.size() < n && k < budget) begin
      step();
      k++;
    end
    got = (done_q.size() >= n);
  endtask

  task automatic do_reset();
    res = 1'b0;
    step();
    step();
    res = 1'b1;
  endtask

  task automatic test_reset();
    res = 1'b0;
    req_valid = '0; req_wr_rd = '0; req_addr = '0; req_wdata = '0;
    oneshot = 4'hF; mem_en = 1'b1;
    step();
    step();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h expected 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0h expected 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant_id: got %0h expected 0", grant_id); end
    checks++; if (req_done !== 4'h0) begin errors++; $display("FAIL rst_req_done: got %0h expected 0", req_done); end
    checks++; if (req_err !== 4'h0) begin errors++; $display("FAIL rst_req_err: got %0h expected 0", req_err); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("FAIL rst_rsp_rdata: got %0h expected 0", rsp_rdata); end
    checks++; if ({wr_rd, addr, wdata} !== 13'h0) begin errors++; $display("FAIL rst_mem_bus: got %0h expected 0", {wr_rd, addr, wdata}); end
    res = 1'b1;
    clear_mon();
  endtask

  task automatic test_write_read();
    clear_mon();
    req_addr[3:0] = 4'd3; req_wdata[7:0] = 8'hA5; req_wr_rd[0] = 1'b1; req_valid[0] = 1'b1;
    step();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL wr_valid_latency: got %0h expected 1", valid); end
    checks++; if ({busy, grant_id} !== 3'b100) begin errors++; $display("FAIL wr_busy_grant: got %0h expected 4", {busy, grant_id}); end
    checks++; if ({wr_rd, addr, wdata} !== {1'b1, 4'd3, 8'hA5}) begin errors++; $display("FAIL wr_bus: got %0h expected %0h", {wr_rd, addr, wdata}, {1'b1, 4'd3, 8'hA5}); end
    run_until(1, 20, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_done_timeout: got %0d completions expected 1", done_q.size()); end
    checks++; if (done_q[0] !== 4'b0001) begin errors++; $display("FAIL wr_done: got %0h expected 1", done_q[0]); end
    checks++; if (err_q[0] !== 4'b0000) begin errors++; $display("FAIL wr_err: got %0h expected 0", err_q[0]); end
    req_wr_rd[0] = 1'b0; req_valid[0] = 1'b1;
    run_until(2, 20, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rd_done_timeout: got %0d completions expected 2", done_q.size()); end
    checks++; if (done_q[1] !== 4'b0001) begin errors++; $display("FAIL rd_done: got %0h expected 1", done_q[1]); end
    checks++; if (rdata_q[1] !== 8'hA5) begin errors++; $display("FAIL rd_data: got %0h expected a5", rdata_q[1]); end
    checks++; if (rise_cnt !== 2) begin errors++; $display("FAIL wr_rd_valid_pulses: got %0d expected 2", rise_cnt); end
    step();
    step();
    checks++; if (rsp_rdata !== 8'hA5) begin errors++; $display("FAIL rd_data_hold: got %0h expected a5", rsp_rdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle_busy: got %0h expected 0", busy); end
  endtask

  task automatic test_all_agents();
    do_reset();
    clear_mon();
    req_wr_rd = 4'h0; req_addr = {4'd3, 4'd3, 4'd3, 4'd3};
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    req_valid = 4'hF;
    run_until(4, 40, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL all_done_timeout: got %0d completions expected 4", done_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (grant_q[i] !== exp_q[i]) begin errors++; $display("FAIL all_grant_%0d: got %0h expected %0h", i, grant_q[i], exp_q[i]); end
      checks++; if (done_q[i] !== (4'b0001 << exp_q[i])) begin errors++; $display("FAIL all_done_%0d: got %0h expected %0h", i, done_q[i], 4'b0001 << exp_q[i]); end
      checks++; if (rdata_q[i] !== 8'hA5) begin errors++; $display("FAIL all_rdata_%0d: got %0h expected a5", i, rdata_q[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (gap_q[i] !== 1) begin errors++; $display("FAIL all_gap_%0d: got %0d idle cycles expected 1", i, gap_q[i]); end
    end
    checks++; if (rise_cnt !== 4) begin errors++; $display("FAIL all_valid_pulses: got %0d expected 4", rise_cnt); end
  endtask

  task automatic test_rr_fairness();
    clear_mon();
    req_valid = 4'b0010;
    run_until(1, 20, ok);
    checks++; if (done_q[0] !== 4'b0010) begin errors++; $display("FAIL rr_setup_done: got %0h expected 2", done_q[0]); end
    clear_mon();
    oneshot = 4'b0001;
    req_valid = 4'b1010;
    run_until(4, 40, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_hold_timeout: got %0d completions expected 4", done_q.size()); end
    req_valid[0] = 1'b1;
    run_until(6, 40, ok);
    req_valid = 4'b0000;
    oneshot = 4'hF;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rr_late_timeout: got %0d completions expected 6", done_q.size()); end
    exp_q = '{2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd0};
    for (int i = 0; i < 6; i++) begin
      checks++; if (grant_q[i] !== exp_q[i]) begin errors++; $display("FAIL rr_grant_%0d: got %0h expected %0h", i, grant_q[i], exp_q[i]); end
      checks++; if (done_q[i] !== (4'b0001 << exp_q[i])) begin errors++; $display("FAIL rr_done_%0d: got %0h expected %0h", i, done_q[i], 4'b0001 << exp_q[i]); end
    end
    step();
    step();
    checks++; if (rise_cnt !== 6) begin errors++; $display("FAIL rr_no_extra_grant: got %0d expected 6", rise_cnt); end
  endtask

  task automatic test_timeout();
    clear_mon();
    mem_en = 1'b0;
    req_addr[11:8] = 4'd3; req_wr_rd[2] = 1'b0; req_valid = 4'b0100;
    run_until(1, 30, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_done_timeout: got %0d completions expected 1", done_q.size()); end
    checks++; if (high_cnt !== TIMEOUT) begin errors++; $display("FAIL tmo_valid_cycles: got %0d expected %0d", high_cnt, TIMEOUT); end
    checks++; if (done_q[0] !== 4'b0100) begin errors++; $display("FAIL tmo_done: got %0h expected 4", done_q[0]); end
    checks++; if (err_q[0] !== 4'b0100) begin errors++; $display("FAIL tmo_err: got %0h expected 4", err_q[0]); end
    checks++; if (rdata_q[0] !== 8'h00) begin errors++; $display("FAIL tmo_rdata: got %0h expected 0", rdata_q[0]); end
    checks++; if ({busy, valid, grant_id} !== 4'b0010) begin errors++; $display("FAIL tmo_after: got %0h expected 2", {busy, valid, grant_id}); end
    mem_en = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    clear_mon();
    req_addr[7:4] = 4'd3; req_wr_rd[1] = 1'b0; req_valid = 4'b0010;
    step();
    checks++; if ({valid, grant_id} !== 3'b101) begin errors++; $display("FAIL mid_pre_grant: got %0h expected 5", {valid, grant_id}); end
    #2 res = 1'b0;
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %0h expected 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy: got %0h expected 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_async_grant: got %0h expected 0", grant_id); end
    req_addr[3:0] = 4'd3; req_wr_rd[0] = 1'b0; req_valid = 4'b0011;
    step();
    step();
    checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL mid_no_done: got %0d completions expected 0", done_q.size()); end
    res = 1'b1;
    clear_mon();
    run_until(2, 40, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL mid_done_timeout: got %0d completions expected 2", done_q.size()); end
    checks++; if (grant_q[0] !== 2'd0) begin errors++; $display("FAIL mid_first_grant: got %0h expected 0", grant_q[0]); end
    checks++; if (done_q[0] !== 4'b0001) begin errors++; $display("FAIL mid_done0: got %0h expected 1", done_q[0]); end
    checks++; if (done_q[1] !== 4'b0010) begin errors++; $display("FAIL mid_done1: got %0h expected 2", done_q[1]); end
  endtask

  task automatic test_addr_stable();
    clear_mon();
    req_addr[15:12] = 4'd5; req_wdata[31:24] = 8'h3C; req_wr_rd[3] = 1'b1; req_valid = 4'b1000;
    step();
    checks++; if ({valid, grant_id, addr} !== {1'b1, 2'd3, 4'd5}) begin errors++; $display("FAIL stab_grant: got %0h expected %0h", {valid, grant_id, addr}, {1'b1, 2'd3, 4'd5}); end
    req_addr[15:12] = 4'd9;
    step();
    checks++; if ({valid, addr} !== {1'b1, 4'd5}) begin errors++; $display("FAIL stab_mid_addr: got %0h expected %0h", {valid, addr}, {1'b1, 4'd5}); end
    run_until(1, 20, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stab_done_timeout: got %0d completions expected 1", done_q.size()); end
    checks++; if (done_q[0] !== 4'b1000) begin errors++; $display("FAIL stab_done: got %0h expected 8", done_q[0]); end
    checks++; if (addr !== 4'd5) begin errors++; $display("FAIL stab_addr_after: got %0h expected 5", addr); end
    step();
    step();
    step();
    checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL stab_single_done: got %0d expected 1", done_q.size()); end
    checks++; if (rise_cnt !== 1) begin errors++; $display("FAIL stab_single_valid: got %0d expected 1", rise_cnt); end
    checks++; if (mem[5] !== 8'h3C) begin errors++; $display("FAIL stab_mem5: got %0h expected 3c", mem[5]); end
    checks++; if (mem[9] !== 8'h00) begin errors++; $display("FAIL stab_mem9: got %0h expected 0", mem[9]); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_all_agents();
    test_rr_fairness();
    test_timeout();
    test_reset_mid();
    test_addr_stable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
